// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the host memory loader / CPU run controller.
package mem_loader_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'd0,
        CMD_READ  = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_HALT  = 2'd3
    } cmdT;

    typedef enum logic [1:0] {
        StHalt,
        StRsp,
        StRun
    } stateT;

    localparam int unsigned CH_IMEM = 0;
    localparam int unsigned CH_DMEM = 1;

endpackage

// File: rtl/mem_port_mux.sv
// One memory channel's port select: host loader side when halted, CPU side while running.
module mem_port_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              cpuSel,
    input  logic              hostWe,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWdata,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata
);

    always_comb begin
        memWe    = hostWe;
        memAddr  = hostAddr;
        memWdata = hostWdata;
        if (cpuSel) begin
            memWe    = cpuWe;
            memAddr  = cpuAddr;
            memWdata = cpuWdata;
        end
    end

endmodule

// File: rtl/mem_loader_ctrl.sv
// Host-side memory loader and run controller: preload/read back memories with the CPU
// held in reset, then release the CPU and count run cycles until HALT or auto-halt.
module mem_loader_ctrl
    import mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned NUM_MEM   = 2,
    parameter int unsigned RUN_LIMIT = 0,
    localparam int unsigned SEL_W    = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      h_valid,
    output logic                      h_ready,
    input  logic [1:0]                h_cmd,
    input  logic [SEL_W-1:0]          h_sel,
    input  logic [ADDR_W-1:0]         h_addr,
    input  logic [DATA_W-1:0]         h_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      err,
    output logic                      running,
    output logic                      cpu_reset,
    output logic [31:0]               cyc_count,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic [ADDR_W-1:0]         cpu_pc,
    output logic [NUM_MEM-1:0]        mem_we,
    output logic [NUM_MEM*ADDR_W-1:0] mem_addr,
    output logic [NUM_MEM*DATA_W-1:0] mem_wdata,
    input  logic [NUM_MEM*DATA_W-1:0] mem_rdata
);

    stateT              stateQ, stateD;
    logic               errQ, errD;
    logic [DATA_W-1:0]  rdataQ, rdataD;
    logic [31:0]        cycQ, cycD;

    cmdT                cmd;
    logic               accept;
    logic               addrOk;
    logic               selOk;
    logic               rangeOk;
    logic               hostWrite;
    logic [NUM_MEM-1:0] hostWe;
    logic [DATA_W-1:0]  hostRdata;

    assign cmd = cmdT'(h_cmd);

    // Gated by reset so the port closes (and any pending write dies) the instant reset drops.
    assign h_ready   = reset && (stateQ != StRsp);
    assign accept    = h_valid && h_ready;
    assign addrOk    = {2'b00, h_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH);
    assign rangeOk   = addrOk && selOk;
    assign hostWrite = accept && (stateQ == StHalt) && (cmd == CMD_WRITE) && rangeOk;

    always_comb begin
        selOk     = 1'b0;
        hostRdata = '0;
        hostWe    = '0;
        for (int unsigned i = 0; i < NUM_MEM; i++) begin
            if (32'(h_sel) == i) begin
                selOk     = 1'b1;
                hostRdata = mem_rdata[i*DATA_W +: DATA_W];
                hostWe[i] = hostWrite;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        errD   = errQ;
        rdataD = rdataQ;
        cycD   = cycQ;
        unique case (stateQ)
            StHalt: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_WRITE: begin
                            if (!rangeOk) errD = 1'b1;
                        end
                        CMD_READ: begin
                            rdataD = rangeOk ? hostRdata : '0;
                            if (!rangeOk) errD = 1'b1;
                            stateD = StRsp;
                        end
                        CMD_RUN: begin
                            cycD   = '0;
                            stateD = StRun;
                        end
                        CMD_HALT: errD = 1'b0;
                        default: ;
                    endcase
                end
            end
            StRsp: stateD = StHalt;
            StRun: begin
                if (cycQ != '1) cycD = cycQ + 32'd1;
                if ((RUN_LIMIT != 0) && (cycQ == 32'(RUN_LIMIT - 1))) stateD = StHalt;
                // Only HALT is meaningful while the CPU owns the memories.
                if (accept) begin
                    if (cmd == CMD_HALT) begin
                        stateD = StHalt;
                        errD   = 1'b0;
                    end else begin
                        errD = 1'b1;
                    end
                end
            end
            default: stateD = StHalt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StHalt;
            errQ   <= 1'b0;
            rdataQ <= '0;
            cycQ   <= '0;
        end else begin
            stateQ <= stateD;
            errQ   <= errD;
            rdataQ <= rdataD;
            cycQ   <= cycD;
        end
    end

    assign rsp_valid = (stateQ == StRsp);
    assign rsp_rdata = rdataQ;
    assign err       = errQ;
    assign running   = (stateQ == StRun);
    assign cpu_reset = !running;
    assign cyc_count = cycQ;

    for (genvar ch = 0; ch < NUM_MEM; ch++) begin : genPort
        logic              cpuWe;
        logic [ADDR_W-1:0] cpuAddr;
        logic [DATA_W-1:0] cpuWdata;

        if (ch == int'(CH_IMEM)) begin : genImem
            assign cpuWe    = 1'b0;
            assign cpuAddr  = cpu_pc;
            assign cpuWdata = '0;
        end else if (ch == int'(CH_DMEM)) begin : genDmem
            assign cpuWe    = cpu_we;
            assign cpuAddr  = cpu_addr;
            assign cpuWdata = cpu_wdata;
        end else begin : genIdle
            assign cpuWe    = 1'b0;
            assign cpuAddr  = '0;
            assign cpuWdata = '0;
        end

        mem_port_mux #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) uMux (
            .cpuSel   (running),
            .hostWe   (hostWe[ch]),
            .hostAddr (h_addr),
            .hostWdata(h_wdata),
            .cpuWe    (cpuWe),
            .cpuAddr  (cpuAddr),
            .cpuWdata (cpuWdata),
            .memWe    (mem_we[ch]),
            .memAddr  (mem_addr[ch*ADDR_W +: ADDR_W]),
            .memWdata (mem_wdata[ch*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Randomized bench for mem_loader_ctrl: behavioural memories plus an abstract reference model.
module tb_mem_loader_ctrl;
    import mem_loader_pkg::*;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned NUM_MEM   = 3;
    localparam int unsigned RUN_LIMIT = 10;
    localparam int unsigned SEL_W     = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      h_valid;
    logic                      h_ready;
    logic [1:0]                h_cmd;
    logic [SEL_W-1:0]          h_sel;
    logic [ADDR_W-1:0]         h_addr;
    logic [DATA_W-1:0]         h_wdata;
    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      err;
    logic                      running;
    logic                      cpu_reset;
    logic [31:0]               cyc_count;
    logic                      cpu_we;
    logic [ADDR_W-1:0]         cpu_addr;
    logic [DATA_W-1:0]         cpu_wdata;
    logic [ADDR_W-1:0]         cpu_pc;
    logic [NUM_MEM-1:0]        mem_we;
    logic [NUM_MEM*ADDR_W-1:0] mem_addr;
    logic [NUM_MEM*DATA_W-1:0] mem_wdata;
    logic [NUM_MEM*DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] envMem [NUM_MEM][DEPTH];
    logic [DATA_W-1:0] refMem [NUM_MEM][DEPTH];
    logic              memClear;
    logic              errExp;
    int                nVec = 0;
    int                nErr = 0;

    always #5 clk = ~clk;

    mem_loader_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_MEM  (NUM_MEM),
        .RUN_LIMIT(RUN_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .h_valid  (h_valid),
        .h_ready  (h_ready),
        .h_cmd    (h_cmd),
        .h_sel    (h_sel),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .err      (err),
        .running  (running),
        .cpu_reset(cpu_reset),
        .cyc_count(cyc_count),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_pc   (cpu_pc),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural memories: synchronous write, combinational read.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_MEM; i++) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (memClear) envMem[i][w] <= '0;
                else if (mem_we[i] && (32'(mem_addr[i*ADDR_W+2 +: ADDR_W-2]) == w))
                    envMem[i][w] <= mem_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            int unsigned w;
            w = 32'(mem_addr[i*ADDR_W+2 +: ADDR_W-2]);
            if (w < DEPTH) mem_rdata[i*DATA_W +: DATA_W] = envMem[i][w];
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit inRange(input int unsigned sel, input logic [31:0] addr);
        return (sel < NUM_MEM) && ((addr >> 2) < DEPTH);
    endfunction

    // Present one command from HALT; returns 1 ns after its acceptance edge, valid still high.
    task automatic hostCmd(input logic [1:0] cmd, input int unsigned sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit                 ok;
        logic [NUM_MEM-1:0] expWe;
        ok      = inRange(sel, addr);
        h_valid = 1'b1;
        h_cmd   = cmd;
        h_sel   = SEL_W'(sel);
        h_addr  = addr;
        h_wdata = wdata;
        @(negedge clk);
        checkEq("h_ready", h_ready, 1);
        checkEq("rsp_idle", rsp_valid, 0);
        checkEq("err", err, errExp);
        checkEq("cpu_reset", cpu_reset, 1);
        expWe = '0;
        if (cmd == CMD_WRITE && ok) expWe[sel] = 1'b1;
        checkEq("mem_we", mem_we, expWe);
        if (expWe != '0) begin
            checkEq("wr_addr", mem_addr[sel*ADDR_W +: ADDR_W], addr);
            checkEq("wr_data", mem_wdata[sel*DATA_W +: DATA_W], wdata);
        end
        @(posedge clk);
        #1;
        case (cmd)
            CMD_WRITE: if (ok) refMem[sel][addr >> 2] = wdata; else errExp = 1'b1;
            CMD_READ:  if (!ok) errExp = 1'b1;
            CMD_HALT:  errExp = 1'b0;
            default: ;
        endcase
    endtask

    task automatic doRead(input int unsigned sel, input logic [31:0] addr);
        logic [31:0] exp;
        exp = '0;
        if (inRange(sel, addr)) exp = refMem[sel][addr >> 2];
        hostCmd(CMD_READ, sel, addr, 32'h0);
        h_valid = 1'b0;
        @(negedge clk);
        checkEq("rsp_valid", rsp_valid, 1);
        checkEq("rsp_rdata", rsp_rdata, exp);
        checkEq("rsp_ready", h_ready, 0);
        @(posedge clk);
        #1;
    endtask

    // RUN, then script CPU traffic and host commands per run cycle k; -1 disables an event.
    task automatic runSeq(input int haltAt, input int badAt, input int cpuWrAt, input int expRuns);
        bit          expRun;
        bit          hv;
        bit          stop;
        int unsigned expCyc;
        int          runs;
        logic [NUM_MEM-1:0] expWe;
        expRun = 1'b1;
        expCyc = 0;
        runs   = 0;
        hostCmd(CMD_RUN, 0, 32'h0, 32'h0);
        for (int k = 0; k < int'(RUN_LIMIT) + 4; k++) begin
            cpu_pc    = $urandom;
            cpu_we    = (k == cpuWrAt) || (k == int'(RUN_LIMIT) + 1);
            cpu_addr  = (k == cpuWrAt) ? 32'h20 : 32'h24;
            cpu_wdata = (k == cpuWrAt) ? 32'hDEAD : 32'hBEEF;
            hv        = expRun && ((k == haltAt) || (k == badAt));
            h_valid   = hv;
            h_cmd     = (k == haltAt) ? CMD_HALT : CMD_WRITE;
            h_sel     = '0;
            h_addr    = 32'h0;
            h_wdata   = 32'hBAD;
            @(negedge clk);
            checkEq("running", running, expRun);
            checkEq("run_cpu_reset", cpu_reset, !expRun);
            checkEq("cyc_count", cyc_count, expCyc);
            checkEq("run_err", err, errExp);
            checkEq("run_ready", h_ready, 1);
            expWe = '0;
            if (expRun && cpu_we) expWe[1] = 1'b1;
            checkEq("run_mem_we", mem_we, expWe);
            if (expRun) begin
                checkEq("imem_pc", mem_addr[0 +: ADDR_W], cpu_pc);
                checkEq("dmem_addr", mem_addr[ADDR_W +: ADDR_W], cpu_addr);
                checkEq("dmem_wdata", mem_wdata[DATA_W +: DATA_W], cpu_wdata);
                if (cpu_we) refMem[1][cpu_addr >> 2] = cpu_wdata;
                runs++;
            end
            @(posedge clk);
            #1;
            if (expRun) begin
                stop = 1'b0;
                expCyc++;
                if (expCyc >= RUN_LIMIT) stop = 1'b1;
                if (hv && k == haltAt) begin
                    stop   = 1'b1;
                    errExp = 1'b0;
                end else if (hv) begin
                    errExp = 1'b1;
                end
                if (stop) expRun = 1'b0;
            end
        end
        h_valid = 1'b0;
        cpu_we  = 1'b0;
        checkEq("run_cycles", runs, expRuns);
    endtask

    initial begin
        reset     = 1'b0;
        memClear  = 1'b1;
        h_valid   = 1'b0;
        h_cmd     = '0;
        h_sel     = '0;
        h_addr    = '0;
        h_wdata   = '0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_pc    = '0;
        errExp    = 1'b0;
        for (int i = 0; i < NUM_MEM; i++)
            for (int w = 0; w < DEPTH; w++) refMem[i][w] = '0;

        #2;
        checkEq("rst_ready", h_ready, 0);
        checkEq("rst_cpu_reset", cpu_reset, 1);
        checkEq("rst_running", running, 0);
        checkEq("rst_rsp_valid", rsp_valid, 0);
        checkEq("rst_rsp_rdata", rsp_rdata, 0);
        checkEq("rst_err", err, 0);
        checkEq("rst_cyc", cyc_count, 0);
        checkEq("rst_mem_we", mem_we, 0);
        @(posedge clk);
        #1 memClear = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset dropped in the middle of a write burst.
        hostCmd(CMD_WRITE, 1, 4 * DEPTH, 32'h5);
        hostCmd(CMD_WRITE, 0, 32'h10, 32'hA1);
        hostCmd(CMD_WRITE, 0, 32'h14, 32'hA2);
        h_cmd   = CMD_WRITE;
        h_addr  = 32'h18;
        h_wdata = 32'hA3;
        #2 reset = 1'b0;
        #1;
        checkEq("abort_mem_we", mem_we, 0);
        checkEq("abort_ready", h_ready, 0);
        h_valid = 1'b0;
        errExp  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkEq("rel_cpu_reset", cpu_reset, 1);
        checkEq("rel_ready", h_ready, 1);
        checkEq("rel_cyc", cyc_count, 0);
        checkEq("rel_err", err, 0);
        @(posedge clk);
        #1;

        // Reset dropped while the CPU runs.
        hostCmd(CMD_RUN, 0, 32'h0, 32'h0);
        h_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkEq("mid_run_cyc", cyc_count, 3);
        #1 reset = 1'b0;
        #1;
        checkEq("abort_run_cpu_reset", cpu_reset, 1);
        checkEq("abort_run_running", running, 0);
        checkEq("abort_run_cyc", cyc_count, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Back-to-back write burst then read-back.
        hostCmd(CMD_WRITE, 0, 32'h0, 32'h11);
        hostCmd(CMD_WRITE, 0, 32'h4, 32'h22);
        hostCmd(CMD_WRITE, 0, 32'h8, 32'h33);
        hostCmd(CMD_WRITE, 0, 32'hC, 32'h44);
        doRead(0, 32'h8);
        checkEq("read_0x8", rsp_rdata, 32'h33);

        // Range errors and HALT clearing err.
        hostCmd(CMD_WRITE, 1, 4 * DEPTH, 32'h99);
        hostCmd(CMD_HALT, 0, 32'h0, 32'h0);
        h_valid = 1'b0;
        @(negedge clk);
        checkEq("err_cleared", err, 0);
        @(posedge clk);
        #1;
        doRead(3, 32'h0);
        hostCmd(CMD_WRITE, 2, 4 * (DEPTH - 1), 32'h77);
        doRead(2, 4 * (DEPTH - 1));
        hostCmd(CMD_HALT, 0, 32'h0, 32'h0);

        // Auto-halt run with a CPU data write and an illegal host WRITE.
        runSeq(-1, 4, 2, 10);
        checkEq("final_cyc", cyc_count, 10);
        hostCmd(CMD_HALT, 0, 32'h0, 32'h0);
        doRead(1, 32'h20);
        checkEq("dmem_0x20", rsp_rdata, 32'hDEAD);
        doRead(0, 32'h0);
        checkEq("imem_0x0", rsp_rdata, 32'h11);

        // Host HALT mid-run, then HALT coinciding with auto-halt.
        runSeq(3, 1, -1, 4);
        hostCmd(CMD_WRITE, 0, 4 * DEPTH + 8, 32'h1);
        runSeq(9, -1, -1, 10);

        for (int n = 0; n < 200; n++) begin
            int unsigned r;
            int unsigned sel;
            int unsigned haltAt;
            logic [31:0] addr;
            r    = $urandom_range(0, 9);
            sel  = $urandom_range(0, 3);
            addr = ($urandom_range(0, DEPTH + 3) << 2) | $urandom_range(0, 3);
            if (r < 5) begin
                hostCmd(CMD_WRITE, sel, addr, $urandom);
            end else if (r < 8) begin
                doRead(sel, addr);
            end else if (r < 9) begin
                hostCmd(CMD_HALT, 0, 32'h0, 32'h0);
            end else begin
                haltAt = $urandom_range(0, 12);
                runSeq(int'(haltAt), -1, int'($urandom_range(0, 9)),
                       (haltAt < RUN_LIMIT) ? int'(haltAt) + 1 : int'(RUN_LIMIT));
            end
        end
        h_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NUM_MEM; i++)
            for (int w = 0; w < DEPTH; w++)
                checkEq("mem_image", envMem[i][w], refMem[i][w]);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/mem_loader_ctrl.md
# mem_loader_ctrl

Parametrised host-side loader and run controller for the single-cycle RISC-V test top. It holds the CPU in reset while an external host preloads or reads back any of NUM_MEM word-addressed memories (instruction, data, ...) over a valid/ready command port. On a RUN command it releases the CPU, muxes the memory ports to the CPU, and counts run cycles, with an optional automatic halt. It replaces the fixed reset-gated write mux with a generalised, multi-channel, bidirectional loader.

## Interface
- DATA_W, 32, memory word width
- ADDR_W, 32, byte-address width on host and CPU sides
- DEPTH, 64, words per memory channel; word index = addr[ADDR_W-1:2]
- NUM_MEM, 2, number of memory channels (0 = instruction, 1 = data, ...)
- RUN_LIMIT, 0, auto-halt after this many RUN cycles; 0 = unlimited
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- h_valid / h_ready  in / out  1  command handshake; transfer when both high at a clock edge
- h_cmd  in  2  0 WRITE, 1 READ, 2 RUN, 3 HALT
- h_sel  in  $clog2(NUM_MEM) (min 1)  target memory channel
- h_addr  in  ADDR_W  byte address (bits [1:0] ignored)
- h_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse carrying READ data
- rsp_rdata  out  DATA_W  READ data, held until next response
- err  out  1  sticky error flag, cleared by reset or an accepted HALT
- running  out  1  high in RUN state
- cpu_reset  out  1  active-high reset to riscv_cpu; high in every state except RUN
- cyc_count  out  32  RUN cycles since last RUN command
- cpu_we, cpu_addr, cpu_wdata  in  1/ADDR_W/DATA_W  CPU data-memory request
- cpu_pc  in  ADDR_W  CPU instruction address
- mem_we  out  NUM_MEM  per-channel write enable
- mem_addr  out  NUM_MEM*ADDR_W  per-channel address, flattened, channel 0 in LSBs
- mem_wdata  out  NUM_MEM*DATA_W  per-channel write data, flattened
- mem_rdata  in  NUM_MEM*DATA_W  per-channel combinational read data

## Operation
- States: HALT (reset state), RSP, RUN.
- HALT: h_ready=1. WRITE pulses mem_we[h_sel] for exactly the acceptance cycle, with mem_addr/mem_wdata of that channel driven combinationally from h_addr/h_wdata. READ latches mem_rdata[h_sel] at the acceptance edge and goes to RSP. RUN clears cyc_count and goes to RUN. HALT is a no-op that clears err.
- RSP: h_ready=0. rsp_valid=1 for one cycle, then return to HALT.
- RUN: cpu_reset=0 and running=1. Channel 0 addr = cpu_pc. Channel 1 addr/wdata/we come from the CPU. Channels >=2 are idle (we=0). h_ready=1, but only HALT is legal. HALT is accepted and moves to HALT the next edge with cpu_reset=1. Any other command is accepted, discarded, and sets err.
- Range check on WRITE/READ: if word index >= DEPTH or h_sel >= NUM_MEM, set err. WRITE is suppressed. READ returns 0 with rsp_valid still pulsed.
- cyc_count increments each RUN cycle and saturates at 2^32-1. If RUN_LIMIT != 0 and cyc_count reaches RUN_LIMIT-1 on an edge, go to HALT on that edge; cyc_count holds RUN_LIMIT.
- An accepted HALT and auto-halt in the same cycle: single transition to HALT, err cleared.
- Outside RUN, CPU-side inputs are ignored.

## Timing
- Reset values: h_ready=0 while reset low, then 1. rsp_valid=0, rsp_rdata=0, err=0, running=0, cpu_reset=1, cyc_count=0, mem_we=0.
- WRITE: zero-latency, memory written at the edge after acceptance. Back-to-back WRITEs run at one per cycle.
- READ: rsp_valid the cycle after acceptance. Next command is accepted no earlier than 2 cycles after the READ.
- RUN: the first CPU cycle out of reset is the cycle after acceptance.
- HALT: cpu_reset asserts the cycle after acceptance. Memory muxes switch back to host in that same cycle.
- Reset mid-operation (any state): abort immediately, no write issued, CPU held in reset.

## Structure
- Shared package mem_loader_pkg: cmd enum (CMD_WRITE/READ/RUN/HALT), state enum, channel index constants (CH_IMEM=0, CH_DMEM=1).
- One sub-module, mem_port_mux: per-channel host/CPU select for we/addr/wdata, generated NUM_MEM times.

## Test plan
- Reset low mid-WRITE burst -> mem_we=0 immediately. After release: cpu_reset=1, h_ready=1, all counters 0.
- WRITE ch0 addr 0x0..0xC data 0x11..0x44 back-to-back, then READ ch0 0x8 -> rsp_valid one cycle later with 0x33.
- WRITE ch1 addr 4*DEPTH -> err=1, no mem_we. Then HALT -> err=0.
- RUN with RUN_LIMIT=10 -> cpu_reset=0 for exactly 10 cycles, cyc_count=10, back in HALT.
- In RUN, CPU drives cpu_we=1 addr 0x20 data 0xDEAD -> mem_we[1]=1. Then HALT, READ ch1 0x20 -> 0xDEAD.
- WRITE issued during RUN -> err=1, memory unchanged, CPU keeps running.
